// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg -- shared constants for the instruction-memory bootloader.
//   ST_*      : loader FSM state encoding
//   ERR_*     : err_code values reported on abort
//   SYNC_BYTE_DEFAULT : default frame header byte
package imem_loader_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CNT_LO = 3'd1;
  localparam logic [2:0] ST_CNT_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CHK    = 3'd4;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_COUNT   = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/loader_word_asm.sv
// loader_word_asm -- assembles four little-endian bytes into a 32-bit word.
//   clk, reset  : clock, synchronous active-high reset
//   clr_i       : drop any partial word (held while the loader is not in DATA)
//   valid_i     : byte_i carries a payload byte this cycle
//   byte_i      : payload byte
//   word_o      : assembled word, meaningful only while word_rdy_o is high
//   word_rdy_o  : high in the cycle the 4th byte of a word is presented
module loader_word_asm (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_rdy_o
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  // NOTE: every variable driven here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (valid_i) begin
      // Newest byte enters at the top, so byte0 ends up in bits [7:0].
      shift_d = {byte_i, shift_q[23:8]};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  // The 4th byte is combined straight from the input so the write can be
  // registered on the same edge that samples it.
  assign word_o     = {byte_i, shift_q};
  assign word_rdy_o = valid_i && !clr_i && (cnt_q == 2'd3);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader -- UART byte-stream bootloader for the 256 x 32 instruction memory.
// Frame: SYNC, CNT_LO, CNT_HI, 4*N little-endian payload bytes, XOR checksum.
//   clk, reset          : clock, synchronous active-high reset
//   rx_valid, rx_byte   : one-cycle strobe and byte from the UART receiver
//   mem_we/addr/wdata   : instruction memory write port (addr/wdata hold when idle)
//   cpu_hold            : keeps the core in reset while a frame is loading
//   load_done, load_err : one-cycle completion / abort pulses
//   err_code            : sticky cause of the last abort (ERR_* codes)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         DEPTH          = 256,
  parameter int         ADDR_W         = 8,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        err_code
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [2:0]        state_q, state_d;
  logic [7:0]        cnt_lo_q, cnt_lo_d;
  logic [15:0]       n_q, n_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        csum_q, csum_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;

  logic              abort;
  logic [1:0]        abort_code;
  logic [31:0]       word;
  logic              word_rdy;
  logic              last_word;

  loader_word_asm u_word_asm (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (state_q != ST_DATA),
    .valid_i    (rx_valid && (state_q == ST_DATA)),
    .byte_i     (rx_byte),
    .word_o     (word),
    .word_rdy_o (word_rdy)
  );

  assign last_word = (16'(idx_q) == (n_q - 16'd1));

  always_comb begin
    state_d    = state_q;
    cnt_lo_d   = cnt_lo_q;
    n_d        = n_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    timer_d    = timer_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    hold_d     = hold_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    code_d     = code_q;
    abort      = 1'b0;
    abort_code = ERR_NONE;

    // timer_q counts cycles since the last byte; a byte on the expiry cycle
    // wins, so the abort is only taken when rx_valid is low.
    if (state_q != ST_IDLE) begin
      timer_d = rx_valid ? TW'(1) : timer_q + TW'(1);
      if (!rx_valid && (timer_d == TW'(TIMEOUT_CYCLES - 1))) begin
        abort      = 1'b1;
        abort_code = ERR_TIMEOUT;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_byte == SYNC_BYTE)) begin
          state_d = ST_CNT_LO;
          hold_d  = 1'b1;
          timer_d = TW'(1);
        end
      end
      ST_CNT_LO: begin
        if (rx_valid) begin
          cnt_lo_d = rx_byte;
          state_d  = ST_CNT_HI;
        end
      end
      ST_CNT_HI: begin
        if (rx_valid) begin
          n_d = {rx_byte, cnt_lo_q};
          if ((n_d == 16'd0) || (n_d > 16'(DEPTH))) begin
            abort      = 1'b1;
            abort_code = ERR_COUNT;
          end else begin
            state_d = ST_DATA;
            idx_d   = '0;
            csum_d  = '0;
          end
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          csum_d = csum_q ^ rx_byte;
          if (word_rdy) begin
            we_d    = 1'b1;
            addr_d  = idx_q;
            wdata_d = word;
            // Index stops at N-1; the write pulse lands in the first CHK cycle.
            if (last_word) state_d = ST_CHK;
            else           idx_d   = idx_q + ADDR_W'(1);
          end
        end
      end
      ST_CHK: begin
        if (rx_valid) begin
          if (rx_byte == csum_q) begin
            done_d  = 1'b1;
            hold_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            abort      = 1'b1;
            abort_code = ERR_CSUM;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      hold_d  = 1'b0;
      code_d  = abort_code;
    end

    if (state_d == ST_IDLE) timer_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_lo_q <= '0;
      n_q      <= '0;
      idx_q    <= '0;
      csum_q   <= '0;
      timer_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      hold_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      cnt_lo_q <= cnt_lo_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      csum_q   <= csum_d;
      timer_q  <= timer_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = hold_q;
  assign load_done = done_q;
  assign load_err  = err_q;
  assign err_code  = code_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader -- self-checking bench for imem_loader (TIMEOUT_CYCLES = 16).
// Frames are built from word lists; expected writes, pulses, pulse timing,
// cpu_hold duration and the sticky error code come from the frame rules.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int DEPTH = 256;
  localparam int TO    = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [1:0]  err_code;

  imem_loader #(
    .DEPTH          (DEPTH),
    .ADDR_W         (8),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- output monitor (samples on the falling edge) -----------
  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          c;
  } wr_t;

  wr_t wr_q[$];
  int  done_n, err_n, done_c, err_c, hold_n;

  always @(negedge clk) begin
    if (mem_we) wr_q.push_back('{mem_addr, mem_wdata, cyc});
    if (load_done) begin done_n++; done_c = cyc; end
    if (load_err)  begin err_n++;  err_c  = cyc; end
    if (cpu_hold) hold_n++;
  end

  task automatic reset_mon();
    wr_q.delete();
    done_n = 0; err_n = 0; done_c = -1; err_c = -1; hold_n = 0;
  endtask

  // ---------------- stimulus helpers (drive #1 after posedge) --------------
  logic [31:0] pay_q[$];   // words of the frame being sent
  int          quad_c[$];  // cycle of each word's 4th byte
  int          byte_c;     // cycle of the most recent byte
  int          sync_c;     // cycle of the SYNC byte

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    byte_c   = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] n, input bit good, input int gmax);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    quad_c.delete();
    send_byte(8'hA5);
    sync_c = byte_c;
    idle($urandom_range(0, gmax));
    send_byte(n[7:0]);
    idle($urandom_range(0, gmax));
    send_byte(n[15:8]);
    if (n != 16'd0 && int'(n) <= DEPTH) begin
      for (int w = 0; w < int'(n); w++) begin
        for (int k = 0; k < 4; k++) begin
          idle($urandom_range(0, gmax));
          b  = 8'(pay_q[w] >> (8 * k));
          cs = cs ^ b;
          send_byte(b);
          if (k == 3) quad_c.push_back(byte_c);
        end
      end
      idle($urandom_range(0, gmax));
      send_byte(good ? cs : ~cs);
    end
  endtask

  task automatic fill_payload(input int n);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back($urandom());
  endtask

  task automatic verify(input string tag, input int exp_nwr, input bit exp_done,
                        input logic [1:0] exp_code);
    idle(2);
    check({tag, " write count"}, wr_q.size(), exp_nwr);
    for (int i = 0; i < wr_q.size() && i < exp_nwr; i++) begin
      check($sformatf("%s addr[%0d]", tag, i), wr_q[i].addr, i);
      check($sformatf("%s data[%0d]", tag, i), wr_q[i].data, pay_q[i]);
      check($sformatf("%s latency[%0d]", tag, i), wr_q[i].c, quad_c[i] + 1);
    end
    check({tag, " done pulses"}, done_n, exp_done ? 1 : 0);
    check({tag, " err pulses"}, err_n, exp_done ? 0 : 1);
    check({tag, " pulse cycle"}, exp_done ? done_c : err_c, byte_c + 1);
    check({tag, " hold cycles"}, hold_n, byte_c - sync_c);
    check({tag, " err_code"}, err_code, exp_code);
    check({tag, " hold after"}, cpu_hold, 0);
  endtask

  // ---------------- table of framed loads --------------------------------
  typedef struct {
    logic [15:0] n;
    bit          good;
    bit          exp_done;
    logic [1:0]  exp_code;   // err_code after the frame (sticky)
  } vec_t;

  vec_t tbl[7];
  logic [1:0] model_code;
  int         nv;

  initial begin
    tbl[0] = '{16'd2,     1'b1, 1'b1, ERR_NONE};
    tbl[1] = '{16'd0,     1'b1, 1'b0, ERR_COUNT};
    tbl[2] = '{16'd1,     1'b1, 1'b1, ERR_COUNT};
    tbl[3] = '{16'd257,   1'b1, 1'b0, ERR_COUNT};
    tbl[4] = '{16'd1,     1'b0, 1'b0, ERR_CSUM};
    tbl[5] = '{16'd256,   1'b1, 1'b1, ERR_CSUM};
    tbl[6] = '{16'hFFFF,  1'b1, 1'b0, ERR_COUNT};

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    reset_mon();
    @(posedge clk); #1;
    idle(2);
    reset = 1'b0;
    check("reset mem_we", mem_we, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset mem_wdata", mem_wdata, 0);
    check("reset cpu_hold", cpu_hold, 0);
    check("reset load_done", load_done, 0);
    check("reset load_err", load_err, 0);
    check("reset err_code", err_code, ERR_NONE);

    // Two-word load sent back-to-back.
    reset_mon();
    pay_q = '{32'h00500093, 32'h00A00113};
    send_frame(16'd2, 1'b1, 0);
    verify("basic", 2, 1'b1, ERR_NONE);
    check("basic addr hold", mem_addr, 1);
    check("basic data hold", mem_wdata, 32'h00A00113);

    // Garbage in IDLE is ignored.
    reset_mon();
    send_byte(8'h00);
    send_byte(8'hFF);
    idle(2);
    check("garbage writes", wr_q.size(), 0);
    check("garbage hold", hold_n, 0);
    fill_payload(1);
    send_frame(16'd1, 1'b1, 2);
    verify("garbage load", 1, 1'b1, ERR_NONE);

    // Table-driven frames.
    for (int i = 0; i < 7; i++) begin
      reset_mon();
      nv = (tbl[i].n != 16'd0 && int'(tbl[i].n) <= DEPTH) ? int'(tbl[i].n) : 0;
      fill_payload(nv);
      send_frame(tbl[i].n, tbl[i].good, 2);
      verify($sformatf("vec%0d", i), nv, tbl[i].exp_done, tbl[i].exp_code);
    end

    // Timeout after two payload bytes: abort 15 cycles after the last byte.
    reset_mon();
    send_byte(8'hA5);
    sync_c = byte_c;
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h12);
    send_byte(8'h34);
    idle(20);
    check("timeout err pulses", err_n, 1);
    check("timeout err cycle", err_c, byte_c + 15);
    check("timeout err_code", err_code, ERR_TIMEOUT);
    check("timeout writes", wr_q.size(), 0);
    check("timeout hold cycles", hold_n, byte_c + 14 - sync_c);
    check("timeout hold after", cpu_hold, 0);

    // Bytes landing exactly on the expiry cycle keep the frame alive.
    reset_mon();
    pay_q = '{32'hCAFE0B0B};
    quad_c.delete();
    send_byte(8'hA5);
    sync_c = byte_c;
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h0B);
    send_byte(8'h0B);
    idle(13);
    send_byte(8'hFE);
    idle(13);
    send_byte(8'hCA);
    quad_c.push_back(byte_c);
    send_byte(8'h34);
    verify("expiry byte", 1, 1'b1, ERR_TIMEOUT);

    // Reset in the middle of DATA, then a clean reload from address 0.
    reset_mon();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h44);
    send_byte(8'h33);
    send_byte(8'h22);
    send_byte(8'h11);
    send_byte(8'h88);
    send_byte(8'h77);
    check("pre-reset wdata", mem_wdata, 32'h11223344);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset mem_we", mem_we, 0);
    check("midreset mem_addr", mem_addr, 0);
    check("midreset mem_wdata", mem_wdata, 0);
    check("midreset cpu_hold", cpu_hold, 0);
    check("midreset load_done", load_done, 0);
    check("midreset load_err", load_err, 0);
    check("midreset err_code", err_code, ERR_NONE);
    reset_mon();
    fill_payload(2);
    send_frame(16'd2, 1'b1, 1);
    verify("after reset", 2, 1'b1, ERR_NONE);

    // Random frames with random leading garbage and inter-byte gaps.
    model_code = ERR_NONE;
    for (int r = 0; r < 15; r++) begin
      logic [7:0] g;
      bit         good;
      reset_mon();
      repeat ($urandom_range(0, 2)) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h5A;
        send_byte(g);
        idle($urandom_range(0, 3));
      end
      nv   = $urandom_range(1, 5);
      good = ($urandom_range(0, 9) < 7);
      fill_payload(nv);
      send_frame(16'(nv), good, 3);
      if (!good) model_code = ERR_CSUM;
      verify($sformatf("rand%0d", r), nv, good, model_code);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
